// File: rtl/ex_cdiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared constants for the EX-stage complex divide sequencer:
//                opcode values, FSM state encoding, component widths and
//                helpers to pack/unpack {re,im} operand words.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

  // EX-stage opcodes; the sequencer is started by the decoder on DIV_OP.
  localparam logic [3:0] ADD_OP = 4'b0000;
  localparam logic [3:0] SUB_OP = 4'b0001;
  localparam logic [3:0] MUL_OP = 4'b0010;
  localparam logic [3:0] DIV_OP = 4'b0011;

  // Signed width of one complex component and numerator magnitude width.
  // NUM_W is also the number of divider iterations per quotient.
  localparam int CDIV_W     = 8;
  localparam int CDIV_NUM_W = 2 * CDIV_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_DIV_RE = 3'd2,
    ST_DIV_IM = 3'd3,
    ST_DONE   = 3'd4
  } cdiv_state_e;

  function automatic logic [2*CDIV_W-1:0] cdiv_pack(input logic [CDIV_W-1:0] re,
                                                     input logic [CDIV_W-1:0] im);
    return {re, im};
  endfunction

  function automatic logic [CDIV_W-1:0] cdiv_re(input logic [2*CDIV_W-1:0] x);
    return x[2*CDIV_W-1:CDIV_W];
  endfunction

  function automatic logic [CDIV_W-1:0] cdiv_im(input logic [2*CDIV_W-1:0] x);
    return x[CDIV_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_cdiv_sequencer_cdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cdiv_unit
//  Description : Iterative restoring unsigned divider, one quotient bit per
//                cycle. A start pulse loads num/den; the quotient is produced
//                exactly NUM_W cycles later, signalled by a one-cycle 'done'
//                during which 'quotient' holds the final value. A start in the
//                same cycle as 'done' is accepted so divides can be chained.
//                'abort' cancels any divide in flight.
//  Ports       : clk, rst_n (sync, active low), start, abort,
//                num[NUM_W-1:0], den[DEN_W-1:0] -> done, quotient[NUM_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module cdiv_unit #(
  parameter int NUM_W = 17,
  parameter int DEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_W - 1);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [DEN_W:0]   rem_sh;
  logic [DEN_W:0]   rem_sub;
  logic             fits;

  always_comb begin
    // Partial remainder is always < den, so one extra bit covers the shift.
    rem_sh   = {rem_q, quo_q[NUM_W-1]};
    rem_sub  = rem_sh - {1'b0, den_q};
    fits     = (rem_sh >= {1'b0, den_q});
    quotient = {quo_q[NUM_W-2:0], fits};
    done     = run_q && !abort && (cnt_q == LAST_CNT);

    rem_d = rem_q;
    quo_d = quo_q;
    den_d = den_q;
    cnt_d = cnt_q;
    run_d = run_q;

    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      rem_d = '0;
      quo_d = num;
      den_d = den;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = fits ? rem_sub[DEN_W-1:0] : rem_sh[DEN_W-1:0];
      quo_d = quotient;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_cdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ex_cdiv_sequencer
//  Description : EX-stage multi-cycle complex divide controller.
//                q = ((ac+bd) + (bc-ad)i) / (c^2+d^2) for A={a,b}, B={c,d}.
//                One shared iterative divider computes the real then the
//                imaginary quotient; each is sign-restored and saturated.
//                Holds the front end via 'stall' until the result retires.
//  Ports       : clk, rst_n (sync, active low), start, flush,
//                Data_A/Data_B[2W-1:0] {re,im}, C_Reg[7:0]
//                -> stall, busy, result_valid, Result[2W-1:0],
//                   C_Reg_Out[7:0], div_by_zero, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_cdiv_sequencer
  import ex_pkg::*;
#(
  parameter int W     = CDIV_W,
  parameter int NUM_W = 2 * W + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           flush,
  input  logic [2*W-1:0] Data_A,
  input  logic [2*W-1:0] Data_B,
  input  logic [7:0]     C_Reg,
  output logic           stall,
  output logic           busy,
  output logic           result_valid,
  output logic [2*W-1:0] Result,
  output logic [7:0]     C_Reg_Out,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int PW  = 2 * W;
  localparam int NW1 = NUM_W + 1;
  localparam logic [NUM_W-1:0] POS_LIM = NUM_W'((1 << (W - 1)) - 1);
  localparam logic [NUM_W-1:0] NEG_LIM = NUM_W'(1 << (W - 1));

  cdiv_state_e state_q, state_d;

  logic signed [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [7:0]          creg_q, creg_d;
  logic                re_neg_q, re_neg_d, im_neg_q, im_neg_d;
  logic [NUM_W-1:0]    im_mag_q, im_mag_d;
  logic [PW-1:0]       den_q, den_d;
  logic [W-1:0]        res_re_q, res_re_d, res_im_q, res_im_d;
  logic                ovf_q, ovf_d, dbz_q, dbz_d;

  logic signed [PW-1:0]  p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
  logic signed [NUM_W:0] nr_calc, ni_calc;
  logic [PW-1:0]         den_calc;
  logic [W:0]            sat_res;

  logic                  div_start, div_done;
  logic [NUM_W-1:0]      div_num, div_quot;
  logic [PW-1:0]         div_den;

  // |x| of a signed numerator; the magnitude always fits in NUM_W bits.
  function automatic logic [NUM_W-1:0] mag_of(input logic signed [NUM_W:0] x);
    return x[NUM_W] ? (~x[NUM_W-1:0] + NUM_W'(1)) : x[NUM_W-1:0];
  endfunction

  // Restore the sign and clamp to the W-bit signed range; MSB flags a clamp.
  function automatic logic [W:0] saturate(input logic neg, input logic [NUM_W-1:0] mag);
    logic [W:0] r;
    if (!neg) begin
      if (mag > POS_LIM) r = {1'b1, 1'b0, {(W-1){1'b1}}};
      else               r = {1'b0, mag[W-1:0]};
    end else begin
      if (mag > NEG_LIM) r = {1'b1, 1'b1, {(W-1){1'b0}}};
      else               r = {1'b0, ~mag[W-1:0] + W'(1)};
    end
    return r;
  endfunction

  cdiv_unit #(
    .NUM_W (NUM_W),
    .DEN_W (PW)
  ) u_cdiv_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (flush),
    .num      (div_num),
    .den      (div_den),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    // Products of two W-bit signed values always fit in 2W signed bits.
    p_ac = PW'(a_q) * PW'(c_q);
    p_bd = PW'(b_q) * PW'(d_q);
    p_bc = PW'(b_q) * PW'(c_q);
    p_ad = PW'(a_q) * PW'(d_q);
    p_cc = PW'(c_q) * PW'(c_q);
    p_dd = PW'(d_q) * PW'(d_q);
    nr_calc  = NW1'(p_ac) + NW1'(p_bd);
    ni_calc  = NW1'(p_bc) - NW1'(p_ad);
    // Both squares are non-negative; their sum (max 2^(2W-1)) fits unsigned.
    den_calc = p_cc + p_dd;
    sat_res  = saturate((state_q == ST_DIV_RE) ? re_neg_q : im_neg_q, div_quot);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    creg_d   = creg_q;
    re_neg_d = re_neg_q;
    im_neg_d = im_neg_q;
    im_mag_d = im_mag_q;
    den_d    = den_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    div_start = 1'b0;
    div_num   = im_mag_q;
    div_den   = den_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d  = ST_CALC;
          a_d      = Data_A[2*W-1:W];
          b_d      = Data_A[W-1:0];
          c_d      = Data_B[2*W-1:W];
          d_d      = Data_B[W-1:0];
          creg_d   = C_Reg;
          res_re_d = '0;
          res_im_d = '0;
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          re_neg_d = nr_calc[NUM_W];
          im_neg_d = ni_calc[NUM_W];
          im_mag_d = mag_of(ni_calc);
          den_d    = den_calc;
          if (den_calc == '0) begin
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Real quotient starts straight from the combinational numerator.
            div_start = 1'b1;
            div_num   = mag_of(nr_calc);
            div_den   = den_calc;
            state_d   = ST_DIV_RE;
          end
        end
      end
      ST_DIV_RE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          res_re_d  = sat_res[W-1:0];
          ovf_d     = ovf_q | sat_res[W];
          // Chain the imaginary divide in the same cycle: no idle gap.
          div_start = 1'b1;
          state_d   = ST_DIV_IM;
        end
      end
      ST_DIV_IM: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          res_im_d = sat_res[W-1:0];
          ovf_d    = ovf_q | sat_res[W];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      creg_q   <= '0;
      re_neg_q <= 1'b0;
      im_neg_q <= 1'b0;
      im_mag_q <= '0;
      den_q    <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      creg_q   <= creg_d;
      re_neg_q <= re_neg_d;
      im_neg_q <= im_neg_d;
      im_mag_q <= im_mag_d;
      den_q    <= den_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      // In IDLE the stall must rise with the decoded start so the front end
      // does not advance past the divide; a flush or reset cancels it.
      ST_IDLE:                        stall = start && !flush && rst_n;
      ST_CALC, ST_DIV_RE, ST_DIV_IM:  stall = !flush;
      default:                        stall = 1'b0;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign Result       = {res_re_q, res_im_q};
  assign C_Reg_Out    = creg_q;
  assign div_by_zero  = dbz_q;
  assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_cdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_cdiv_sequencer
//  Description : Self-checking bench for ex_cdiv_sequencer. Expected results
//                are computed by an integer reference model when each divide
//                is launched, queued, and compared when result_valid fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_cdiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [15:0] Data_A;
  logic [15:0] Data_B;
  logic [7:0]  C_Reg;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [15:0] Result;
  logic [7:0]  C_Reg_Out;
  logic        div_by_zero;
  logic        overflow;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  creg;
    logic        dbz;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;

  ex_cdiv_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .Data_A       (Data_A),
    .Data_B       (Data_B),
    .C_Reg        (C_Reg),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .Result       (Result),
    .C_Reg_Out    (C_Reg_Out),
    .div_by_zero  (div_by_zero),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sat8(input int q);
    logic [7:0] r;
    if (q > 127)       r = 8'h7F;
    else if (q < -128) r = 8'h80;
    else               r = q[7:0];
    return r;
  endfunction

  function automatic exp_t model(input logic [15:0] a_pk, input logic [15:0] b_pk,
                                 input logic [7:0] cr, input int due);
    exp_t e;
    int a, b, c, d, den, qr, qi;
    a   = int'($signed(a_pk[15:8]));
    b   = int'($signed(a_pk[7:0]));
    c   = int'($signed(b_pk[15:8]));
    d   = int'($signed(b_pk[7:0]));
    den = c * c + d * d;
    e.creg = cr;
    e.due  = due;
    e.dbz  = 1'b0;
    e.ovf  = 1'b0;
    e.res  = 16'h0000;
    if (den == 0) begin
      e.dbz = 1'b1;
    end else begin
      qr = (a * c + b * d) / den;
      qi = (b * c - a * d) / den;
      e.res = {sat8(qr), sat8(qi)};
      e.ovf = (qr > 127) || (qr < -128) || (qi > 127) || (qi < -128);
    end
    return e;
  endfunction

  // Scoreboard side: every result_valid must match the oldest queued divide.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(result_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",      32'(Result),      32'(e.res));
        check("c_reg_out",   32'(C_Reg_Out),   32'(e.creg));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        check("overflow",    32'(overflow),    32'(e.ovf));
        check("valid_cycle", cyc,              e.due);
      end
    end
  end

  // Called just after a rising edge; leaves just after the edge that samples start.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [7:0] cr);
    start  = 1'b1;
    Data_A = a;
    Data_B = b;
    C_Reg  = cr;
    @(negedge clk);
    check("stall_on_start", 32'(stall), 32'd1);
    sb.push_back(model(a, b, cr, cyc + ((b == 16'h0000) ? 2 : 36)));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_stall, input string tag);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (stall) n++;
      #1;
      if (sb.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end else begin
      check({tag, "_stall_cycles"}, n, exp_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},     32'(stall),        32'd0);
    check({tag, "_busy"},      32'(busy),         32'd0);
    check({tag, "_valid"},     32'(result_valid), 32'd0);
    check({tag, "_result"},    32'(Result),       32'd0);
    check({tag, "_c_reg_out"}, 32'(C_Reg_Out),    32'd0);
    check({tag, "_dbz"},       32'(div_by_zero),  32'd0);
    check({tag, "_ovf"},       32'(overflow),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    Data_A = 16'h0000;
    Data_B = 16'h0000;
    C_Reg  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed divides, issued back to back (start right after DONE).
    do_op(16'h0402, 16'h0101, 8'h05); wait_done(35, "basic");
    do_op(16'h0700, 16'h0200, 8'h11); wait_done(35, "trunc");
    do_op(16'h1234, 16'h0000, 8'h22); wait_done(1,  "dbz");
    do_op(16'h8000, 16'hFF00, 8'h33); wait_done(35, "ovf_pos");
    do_op(16'h8000, 16'h0100, 8'h34); wait_done(35, "min_neg");
    do_op(16'h7F7F, 16'h0101, 8'h35); wait_done(35, "big");

    // Flush mid-divide, then restart in the very next cycle.
    do_op(16'h0402, 16'h0101, 8'h05);
    repeat (9) @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_valid", 32'(result_valid), 32'd0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    do_op(16'h0402, 16'h0101, 8'h06); wait_done(35, "post_flush");

    // Flush arriving in DONE must not suppress the committed result.
    do_op(16'h0700, 16'h0200, 8'h44);
    repeat (35) @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("done_flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_busy", 32'(busy), 32'd0);
    check("done_flush_sb", sb.size(), 0);

    // Start together with flush in IDLE is ignored.
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("idle_flush_busy", 32'(busy), 32'd0);

    // Reset in the middle of a divide; a start held during reset is ignored.
    do_op(16'h0402, 16'h0101, 8'h05);
    repeat (19) @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("post_reset_busy", 32'(busy), 32'd0);

    // Random operands.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (i == 3) ? 16'h0000 : 16'($urandom);
      do_op(ra, rb, 8'($urandom));
      wait_done((rb == 16'h0000) ? 1 : 35, "rand");
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
